// File: rtl/mmc_spi_pkg.sv
// Shared types and defaults for the MMC/SD SPI-mode byte engine.
package mmc_spi_pkg;

  localparam int unsigned SlowHalfDefault = 63;  // 50 MHz / 128 = 390.6 kHz
  localparam int unsigned FastHalfDefault = 1;   // 12.5 MHz
  localparam int unsigned HalfCntW        = 8;
  localparam int unsigned BitCntW         = 3;

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh,
    StDone
  } state_e;

endpackage

// File: rtl/mmc_spi_master_if.sv
// Host-side byte request/response plus MMC/SD card pins for the SPI byte engine.
interface mmc_spi_master_if;

  logic       start;
  logic [7:0] tx_byte;
  logic       cs_assert;
  logic       fast;
  logic [7:0] rx_byte;
  logic       done;
  logic       busy;
  logic       mmc_cs;
  logic       mmc_sclk;
  logic       mmc_do;
  logic       mmc_di;

  modport master (
    input  start, tx_byte, cs_assert, fast, mmc_di,
    output rx_byte, done, busy, mmc_cs, mmc_sclk, mmc_do
  );

  modport slave (
    output start, tx_byte, cs_assert, fast, mmc_di,
    input  rx_byte, done, busy, mmc_cs, mmc_sclk, mmc_do
  );

endinterface

// File: rtl/mmc_spi_master.sv
// SPI mode-0 byte engine for an MMC/SD card: shifts one byte out MSB-first on MOSI while
// capturing the card's reply from MISO, with selectable slow (init) and fast SCLK rates.
module mmc_spi_master
  import mmc_spi_pkg::*;
#(
  parameter int unsigned SLOW_HALF = SlowHalfDefault,
  parameter int unsigned FAST_HALF = FastHalfDefault
) (
  input  logic              clk,
  input  logic              reset_n,
  mmc_spi_master_if.master  bus
);

  localparam logic [HalfCntW-1:0] SlowLoad = HalfCntW'(SLOW_HALF);
  localparam logic [HalfCntW-1:0] FastLoad = HalfCntW'(FAST_HALF);

  state_e              state_q, state_d;
  logic [HalfCntW-1:0] half_q, half_d;
  logic [HalfCntW-1:0] half_ld_q, half_ld_d;
  logic [BitCntW-1:0]  bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          rx_q, rx_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                cs_q, cs_d;
  logic                sclk_q, sclk_d;
  logic                do_q, do_d;
  logic                half_exp;

  assign half_exp = (half_q == '0);

  // One shift register carries both directions: MOSI leaves from bit 7 while MISO enters at bit 0.
  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    half_ld_d = half_ld_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    rx_d      = rx_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    do_d      = do_q;
    unique case (state_q)
      StIdle: begin
        cs_d = ~bus.cs_assert;
        if (bus.start) begin
          half_ld_d = bus.fast ? FastLoad : SlowLoad;
          half_d    = bus.fast ? FastLoad : SlowLoad;
          shift_d   = bus.tx_byte;
          do_d      = bus.tx_byte[7];
          bit_d     = '0;
          busy_d    = 1'b1;
          state_d   = StLow;
        end
      end
      StLow: begin
        if (half_exp) begin
          sclk_d  = 1'b1;
          shift_d = {shift_q[6:0], bus.mmc_di};
          half_d  = half_ld_q;
          state_d = StHigh;
        end else begin
          half_d = half_q - 1'b1;
        end
      end
      StHigh: begin
        if (half_exp) begin
          sclk_d = 1'b0;
          half_d = half_ld_q;
          bit_d  = bit_q + 1'b1;
          if (bit_q == '1) begin
            rx_d    = shift_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            do_d    = 1'b1;
            state_d = StDone;
          end else begin
            do_d    = shift_q[7];
            state_d = StLow;
          end
        end else begin
          half_d = half_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      half_q    <= '0;
      half_ld_q <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_q      <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      do_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      half_ld_q <= half_ld_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rx_q      <= rx_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      do_q      <= do_d;
    end
  end

  assign bus.rx_byte  = rx_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.mmc_cs   = cs_q;
  assign bus.mmc_sclk = sclk_q;
  assign bus.mmc_do   = do_q;

endmodule

// File: tb/tb_mmc_spi_master.sv
// Directed bench for mmc_spi_master: table of byte transfers plus reset/abort/ignore sequences.
module tb_mmc_spi_master;

  localparam logic [1:0] DiLoop = 2'd0;
  localparam logic [1:0] DiOnes = 2'd1;
  localparam logic [1:0] DiCard = 2'd2;

  typedef struct {
    logic [7:0] tx;
    logic       fast;
    logic       cs;
    logic [1:0] mode;
    logic [7:0] card;
    logic [7:0] exp_rx;
    logic       exp_cs;
    int         half_len;
    int         exp_done;
  } vec_t;

  logic clk;
  logic reset_n;
  logic [1:0] di_mode;
  logic [7:0] card_byte;
  logic [7:0] card_sh;
  int         rise_cnt;
  int         n_chk;
  int         n_fail;

  mmc_spi_master_if bus ();

  mmc_spi_master dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Card reply bit: advances after each SCLK rise the bench has observed.
  assign card_sh    = card_byte << rise_cnt;
  assign bus.mmc_di = (di_mode == DiLoop) ? bus.mmc_do :
                      (di_mode == DiOnes) ? 1'b1 : card_sh[7];

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge of the idle cycle after done.
  task automatic run_xfer(input vec_t v, input string nm);
    int         cyc;
    int         run;
    int         bad_len;
    int         cs_bad;
    int         first_rise;
    logic       prev;
    logic [7:0] mosi;
    bus.tx_byte   = v.tx;
    bus.fast      = v.fast;
    bus.cs_assert = v.cs;
    di_mode       = v.mode;
    card_byte     = v.card;
    rise_cnt      = 0;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    chk({nm, ".busy1"}, 32'(bus.busy), 32'd1);
    chk({nm, ".mosi1"}, 32'(bus.mmc_do), 32'(v.tx[7]));
    prev = 1'b0; run = 0; bad_len = 0; cs_bad = 0; first_rise = 0; mosi = '0;
    while (bus.done !== 1'b1 && cyc < 2000) begin
      if (bus.mmc_cs !== v.exp_cs) cs_bad++;
      if (bus.mmc_sclk === prev) begin
        run++;
      end else begin
        if (run != v.half_len) bad_len++;
        run = 1;
        if (bus.mmc_sclk === 1'b1) begin
          if (rise_cnt == 0) first_rise = cyc;
          mosi = {mosi[6:0], bus.mmc_do};
          rise_cnt++;
        end
      end
      prev = bus.mmc_sclk;
      @(negedge clk);
      cyc++;
    end
    if (run != v.half_len) bad_len++;
    chk({nm, ".done_cycle"}, 32'(cyc), 32'(v.exp_done));
    chk({nm, ".busy_at_done"}, 32'(bus.busy), 32'd0);
    chk({nm, ".rx_byte"}, 32'(bus.rx_byte), 32'(v.exp_rx));
    chk({nm, ".sclk_rises"}, 32'(rise_cnt), 32'd8);
    chk({nm, ".mosi_bits"}, 32'(mosi), 32'(v.tx));
    chk({nm, ".first_rise"}, 32'(first_rise), 32'(1 + v.half_len));
    chk({nm, ".phase_len_errs"}, 32'(bad_len), 32'd0);
    chk({nm, ".cs_errs"}, 32'(cs_bad), 32'd0);
    @(negedge clk);
    chk({nm, ".done_pulse"}, 32'(bus.done), 32'd0);
    chk({nm, ".mosi_idle"}, 32'(bus.mmc_do), 32'd1);
  endtask

  initial begin
    vec_t vecs[$];
    int   dummy_clks;
    int   cyc;
    int   dones;
    int   done_cyc;
    int   cs_bad;
    int   rises;
    logic prev;
    logic [7:0] rxc;
    logic [7:0] cmd0 [6];

    n_chk = 0;
    n_fail = 0;
    cmd0[0] = 8'h40; cmd0[1] = 8'h00; cmd0[2] = 8'h00;
    cmd0[3] = 8'h00; cmd0[4] = 8'h00; cmd0[5] = 8'h95;

    //            tx     fast  cs    mode    card   exp_rx exp_cs half done
    vecs.push_back('{8'hA5, 1'b1, 1'b0, DiLoop, 8'hFF, 8'hA5, 1'b1, 2,   33});
    vecs.push_back('{8'h40, 1'b0, 1'b0, DiOnes, 8'hFF, 8'hFF, 1'b1, 64,  1025});
    for (int i = 0; i < 10; i++)
      vecs.push_back('{8'hFF, 1'b1, 1'b0, DiOnes, 8'hFF, 8'hFF, 1'b1, 2, 33});
    for (int i = 0; i < 6; i++)
      vecs.push_back('{cmd0[i], 1'b1, 1'b1, DiCard, 8'hFF, 8'hFF, 1'b0, 2, 33});
    // R1 poll: card answers idle-state 0x01 after CMD0
    vecs.push_back('{8'hFF, 1'b1, 1'b1, DiCard, 8'h01, 8'h01, 1'b0, 2,   33});
    vecs.push_back('{8'h81, 1'b0, 1'b1, DiCard, 8'h5A, 8'h5A, 1'b0, 64,  1025});
    vecs.push_back('{8'h3C, 1'b1, 1'b1, DiLoop, 8'hFF, 8'h3C, 1'b0, 2,   33});

    reset_n       = 1'b1;
    bus.start     = 1'b0;
    bus.tx_byte   = 8'h00;
    bus.cs_assert = 1'b0;
    bus.fast      = 1'b0;
    di_mode       = DiOnes;
    card_byte     = 8'hFF;
    rise_cnt      = 0;
    #3 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.mmc_cs", 32'(bus.mmc_cs), 32'd1);
    chk("reset.mmc_sclk", 32'(bus.mmc_sclk), 32'd0);
    chk("reset.mmc_do", 32'(bus.mmc_do), 32'd1);
    chk("reset.done", 32'(bus.done), 32'd0);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.rx_byte", 32'(bus.rx_byte), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    dummy_clks = 0;
    foreach (vecs[i]) begin
      run_xfer(vecs[i], $sformatf("vec%0d", i));
      if (i >= 2 && i < 12) dummy_clks += rise_cnt;
    end
    chk("dummy.total_clocks", 32'(dummy_clks), 32'd80);

    // start and cs_assert changes during a transfer must be ignored
    bus.tx_byte   = 8'hA5;
    bus.fast      = 1'b1;
    bus.cs_assert = 1'b1;
    di_mode       = DiLoop;
    bus.start     = 1'b1;
    @(negedge clk);
    cyc = 1; dones = 0; done_cyc = 0; cs_bad = 0; rxc = 8'h00;
    while (cyc < 80) begin
      if (cyc == 10) begin
        bus.start     = 1'b1;
        bus.tx_byte   = 8'h00;
        bus.cs_assert = 1'b0;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        dones++;
        done_cyc = cyc;
        rxc = bus.rx_byte;
      end
      if (cyc <= 33 && bus.mmc_cs !== 1'b0) cs_bad++;
      @(negedge clk);
      cyc++;
    end
    chk("ignore.done_count", 32'(dones), 32'd1);
    chk("ignore.done_cycle", 32'(done_cyc), 32'd33);
    chk("ignore.rx_byte", 32'(rxc), 32'hA5);
    chk("ignore.cs_held", 32'(cs_bad), 32'd0);
    chk("ignore.cs_after_idle", 32'(bus.mmc_cs), 32'd1);

    // Asynchronous abort while SCLK is high on bit 4
    bus.tx_byte   = 8'h3C;
    bus.cs_assert = 1'b1;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1; rises = 0; prev = 1'b0;
    while (rises < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.mmc_sclk === 1'b1 && prev === 1'b0) rises++;
      prev = bus.mmc_sclk;
    end
    chk("abort.sclk_high_before", 32'(bus.mmc_sclk), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort.mmc_sclk", 32'(bus.mmc_sclk), 32'd0);
    chk("abort.mmc_cs", 32'(bus.mmc_cs), 32'd1);
    chk("abort.mmc_do", 32'(bus.mmc_do), 32'd1);
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.done", 32'(bus.done), 32'd0);
    chk("abort.rx_byte", 32'(bus.rx_byte), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    chk("abort.no_done", 32'(dones), 32'd0);
    chk("abort.busy_after", 32'(bus.busy), 32'd0);
    run_xfer('{8'hC3, 1'b1, 1'b1, DiLoop, 8'hFF, 8'hC3, 1'b0, 2, 33}, "post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mmc_spi_master.md
# mmc_spi_master

SPI-mode byte engine that drives the MMC/SD card pins of `top` as bus initiator; it is the host-side counterpart of the `mmc_model` card responder used in simulation. The disk controller hands it one byte at a time plus a chip-select request, and it clocks the byte out MSB-first while capturing the card's reply byte. It runs on the system clock (50 MHz, 20 ns period) and provides a slow init rate (≤400 kHz) and a fast data rate.

## Interface
- `SLOW_HALF`, 63, sysclk cycles per SCLK half-period minus 1 in slow mode (50 MHz/128 = 390.6 kHz).
- `FAST_HALF`, 1, sysclk cycles per SCLK half-period minus 1 in fast mode (12.5 MHz).
- `clk` in 1: system clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to transfer `tx_byte`; ignored while `busy`.
- `tx_byte` in 8: byte to send, sampled on the cycle `start` is accepted.
- `cs_assert` in 1: 1 = select card; sampled only while idle.
- `fast` in 1: 1 = FAST_HALF divider, 0 = SLOW_HALF; sampled with `start`.
- `rx_byte` out 8: byte captured from card, valid when `done`, held until next `done`.
- `done` out 1: one-cycle pulse at end of transfer.
- `busy` out 1: transfer in progress.
- `mmc_cs` out 1: card chip-select, active low.
- `mmc_sclk` out 1: SPI clock, idle low.
- `mmc_do` out 1: MOSI (host to card).
- `mmc_di` in 1: MISO (card to host).

## Operation
- SPI mode 0: SCLK idle low. MOSI changes on falling edge (first bit at transfer start). MISO sampled on rising edge. MSB first.
- States:
  - IDLE -> LOW on accepted `start`.
  - LOW -> HIGH when half-counter expires: raise SCLK, sample `mmc_di` into shift LSB.
  - HIGH -> LOW when counter expires and bits remain: drop SCLK, shift next bit onto `mmc_do`.
  - HIGH -> DONE after 8th high phase: drop SCLK.
  - DONE -> IDLE after one cycle; `done`=1 and `rx_byte` updated in DONE.
- Half-counter: 8-bit, loads selected HALF value on every phase entry, expires at 0. Each phase lasts HALF+1 cycles.
- Bit counter: 3 bits, counts high phases, wraps 7->0 at the last bit.
- `mmc_cs` is a register: `mmc_cs <= ~cs_assert` in IDLE only. CS never changes during a transfer.
- Dummy clocks (≥74 for card init) = repeated 0xFF transfers with `cs_assert`=0; the block treats them like any other byte.
- `mmc_do` idles high (1) in IDLE and DONE.
- `start` and a `cs_assert` change in the same idle cycle: CS updates in that cycle, transfer begins next cycle. CS therefore leads the first SCLK edge by ≥HALF+1 cycles.
- `start` while `busy`: dropped, no queuing.
- `reset_n` low mid-transfer: immediate abort to IDLE, no `done`.

## Timing
- Reset values: `mmc_cs`=1, `mmc_sclk`=0, `mmc_do`=1, `rx_byte`=8'h00, `done`=0, `busy`=0.
- Start accepted in cycle 0.
- From cycle 1: `busy`=1 and `mmc_do`=tx_byte[7].
- First SCLK rise: cycle 1+(H+1).
- `done` at cycle 1+16(H+1); `busy` drops at the same time.
- Next `start` is accepted in cycle 2+16(H+1).
- Fast mode: `done` at cycle 33, 34 cycles/byte back-to-back.
- Slow mode: `done` at cycle 1025.

## Structure
- Package `mmc_spi_pkg`: state enum (IDLE, LOW, HIGH, DONE), SLOW_HALF/FAST_HALF defaults, counter width constant.
- Single module; the half-period counter stays inline. No sub-module.

## Test plan
- Reset: hold `reset_n`=0 -> `mmc_cs`=1, `mmc_sclk`=0, `mmc_do`=1, `done`=0, `busy`=0.
- Fast loopback (`mmc_di`=`mmc_do`), `tx_byte`=8'hA5:
  - 8 SCLK rises with period 4 cycles.
  - MOSI bits 1,0,1,0,0,1,0,1.
  - `done` at cycle 33, `rx_byte`=8'hA5.
- Slow mode, `mmc_di` tied 1, `tx_byte`=8'h40:
  - SCLK high and low each 64 cycles.
  - `rx_byte`=8'hFF, `done` at cycle 1025.
- CS sequencing:
  - 10×0xFF with `cs_assert`=0 -> 80 clocks, `mmc_cs` stays 1.
  - Then `cs_assert`=1 with CMD0 bytes 40 00 00 00 00 95 against `mmc_model` -> `mmc_cs`=0 throughout; R1 poll reads 8'h01.
- `start` pulsed mid-transfer, and a `cs_assert` toggle mid-transfer -> both ignored; exactly one `done`; `mmc_cs` unchanged until idle.
- `reset_n` asserted at bit 4 of a transfer -> outputs return to reset values asynchronously; no `done`; next transfer completes normally.
